// File: rtl/cdb_slot_arbiter.sv
// Round-robin issue arbiter that grants one ready execution channel per cycle and
// books that channel's future CDB write-back slot so results never collide.
module cdb_slot_arbiter #(
   parameter int                  NUM_CH   = 4,
   parameter int                  MAX_LAT  = 8,
   parameter logic [4*NUM_CH-1:0] CH_LAT   = {4'd6, 4'd4, 4'd2, 4'd1},
   parameter logic [NUM_CH-1:0]   BLOCKING = 4'b1000
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_flush,
   input  logic [NUM_CH-1:0]         i_req,
   output logic [NUM_CH-1:0]         o_grant,
   output logic                      o_grant_valid,
   output logic                      o_cdb_valid,
   output logic [$clog2(NUM_CH)-1:0] o_cdb_owner,
   output logic [NUM_CH-1:0]         o_busy
);

   localparam int OW = $clog2(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("cdb_slot_arbiter: NUM_CH must be 2..8");
   end
   if (MAX_LAT < 1 || MAX_LAT > 15) begin : g_bad_max_lat
      $error("cdb_slot_arbiter: MAX_LAT must be 1..15");
   end
   for (genvar g = 0; g < NUM_CH; g++) begin : g_lat_chk
      if (CH_LAT[4*g +: 4] == 4'd0 || int'(CH_LAT[4*g +: 4]) > MAX_LAT) begin : g_bad_lat
         $error("cdb_slot_arbiter: CH_LAT entry out of range 1..MAX_LAT");
      end
   end

   logic [MAX_LAT-1:0] slot_valid;
   logic [OW-1:0]      slot_owner [MAX_LAT];
   logic [3:0]         busy_cnt   [NUM_CH];
   logic [3:0]         ch_lat     [NUM_CH];
   logic [OW-1:0]      rr_ptr;
   logic [NUM_CH-1:0]  elig;
   logic [NUM_CH-1:0]  grant;
   logic [OW-1:0]      gidx;
   logic               gfound;
   logic [3:0]         glat;

   // Handshake: i_req[c] is the valid of channel c's issue queue and o_grant[c] is its ready;
   // an instruction issues in exactly the cycle where both are high, with no holding requirement.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_lat[c] = CH_LAT[4*c +: 4];
         o_busy[c] = (busy_cnt[c] != 4'd0);
      end
   end

   // A channel of latency L writes back L cycles from now, which is the slot that sits at
   // index L today; index MAX_LAT never exists, so it is always free.
   always_comb begin
      logic taken;
      elig  = '0;
      taken = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         taken = 1'b0;
         for (int i = 0; i < MAX_LAT; i++) begin
            if (ch_lat[c] == 4'(i)) taken = slot_valid[i];
         end
         elig[c] = i_req[c] & ~i_flush & ~i_rst & ~o_busy[c] & ~taken;
      end
   end

   always_comb begin
      logic [OW:0]   sum;
      logic [OW-1:0] idx;
      grant  = '0;
      gidx   = '0;
      gfound = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum = {1'b0, rr_ptr} + (OW+1)'(k);
         if (int'(sum) >= NUM_CH) sum = sum - (OW+1)'(NUM_CH);
         idx = sum[OW-1:0];
         if (!gfound && elig[idx]) begin
            gfound     = 1'b1;
            grant[idx] = 1'b1;
            gidx       = idx;
         end
      end
      glat = ch_lat[gidx];
   end

   assign o_grant       = grant;
   assign o_grant_valid = gfound;
   assign o_cdb_valid   = slot_valid[0];
   assign o_cdb_owner   = slot_owner[0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         slot_valid <= '0;
         rr_ptr     <= '0;
         for (int i = 0; i < MAX_LAT; i++) slot_owner[i] <= '0;
         for (int c = 0; c < NUM_CH; c++) busy_cnt[c] <= '0;
      end else begin
         if (i_flush) begin
            slot_valid <= '0;
            for (int i = 0; i < MAX_LAT; i++) slot_owner[i] <= '0;
         end else begin
            for (int i = 0; i < MAX_LAT - 1; i++) begin
               slot_valid[i] <= slot_valid[i+1];
               slot_owner[i] <= slot_owner[i+1];
            end
            slot_valid[MAX_LAT-1] <= 1'b0;
            slot_owner[MAX_LAT-1] <= '0;
            // The booked slot lands one below its check index because the pipeline shifts this edge.
            for (int i = 0; i < MAX_LAT; i++) begin
               if (gfound && glat == 4'(i + 1)) begin
                  slot_valid[i] <= 1'b1;
                  slot_owner[i] <= gidx;
               end
            end
            if (gfound) rr_ptr <= (int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1;
         end
         // Loading L-1 frees the unit in cycle t+L, the same cycle its result reaches the CDB.
         for (int c = 0; c < NUM_CH; c++) begin
            if (i_flush || !BLOCKING[c])  busy_cnt[c] <= '0;
            else if (grant[c])            busy_cnt[c] <= ch_lat[c] - 4'd1;
            else if (busy_cnt[c] != 4'd0) busy_cnt[c] <= busy_cnt[c] - 4'd1;
         end
      end
   end

endmodule
